// File: rtl/adder_pkg.sv
// Shared definitions for the chunked pipelined adder: operation encodings,
// default geometry and small decode helpers.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ADDS = 2'b10,
        MODE_SUBS = 2'b11
    } mode_e;

    // Bit 0 of the mode selects subtraction, bit 1 selects saturation.
    function automatic logic mode_is_sub(input logic [1:0] mode);
        return mode[0];
    endfunction

    function automatic logic mode_is_sat(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit registered ripple slice: sum chunk and carry-out are captured
// on the rising edge whenever the pipeline advances.
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0]   w_full;
    logic [CHUNK-1:0] r_sum;
    logic             r_cout;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

    // Capture the chunk result; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_sum  <= w_full[CHUNK-1:0];
            r_cout <= w_full[CHUNK];
        end else begin
            r_sum  <= r_sum;
            r_cout <= r_cout;
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined add/sub with saturation: one CHUNK-bit slice per stage,
// skewed operands, valid-bit bubbles and a global stall from the output side.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = WIDTH / SAFE_CHUNK;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({SAFE_CHUNK{1'b1}});

    if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic w_stall;
    logic w_adv;
    logic w_accept;

    // Stage k inputs: operands (B already inverted for subtraction), carry-in,
    // mode, valid and the lower chunks of the sum produced so far.
    logic [WIDTH-1:0] w_a_in     [STAGES];
    logic [WIDTH-1:0] w_b_in     [STAGES];
    logic [WIDTH-1:0] w_psum_in  [STAGES];
    logic [1:0]       w_mode_in  [STAGES];
    logic             w_v_in     [STAGES];
    logic             w_cin      [STAGES];

    logic [WIDTH-1:0] r_a        [STAGES];
    logic [WIDTH-1:0] r_b        [STAGES];
    logic [WIDTH-1:0] r_psum     [STAGES];
    logic [1:0]       r_mode     [STAGES];
    logic             r_v        [STAGES];

    logic [CHUNK-1:0] w_slice_sum  [STAGES];
    logic             w_slice_cout [STAGES];
    logic [WIDTH-1:0] w_psum_out   [STAGES];

    logic [WIDTH-1:0] w_result;
    logic             w_flag;
    logic             w_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_carry;
    logic             r_out_ovf;

    assign w_stall  = r_out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_a_in[k]    = in_a;
            assign w_b_in[k]    = mode_is_sub(in_mode) ? ~in_b : in_b;
            assign w_cin[k]     = mode_is_sub(in_mode);
            assign w_mode_in[k] = in_mode;
            assign w_v_in[k]    = w_accept;
            assign w_psum_in[k] = '0;
        end else begin : g_body
            assign w_a_in[k]    = r_a[k-1];
            assign w_b_in[k]    = r_b[k-1];
            assign w_cin[k]     = w_slice_cout[k-1];
            assign w_mode_in[k] = r_mode[k-1];
            assign w_v_in[k]    = r_v[k-1];
            assign w_psum_in[k] = w_psum_out[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .clk    (clk),
            .i_en   (w_adv),
            .i_a    (w_a_in[k][k*CHUNK +: CHUNK]),
            .i_b    (w_b_in[k][k*CHUNK +: CHUNK]),
            .i_cin  (w_cin[k]),
            .o_sum  (w_slice_sum[k]),
            .o_cout (w_slice_cout[k])
        );

        // Merge this stage's freshly computed chunk into the skewed partial sum.
        assign w_psum_out[k] = (r_psum[k] & ~(LOW_MASK << (k*CHUNK)))
                             | (WIDTH'(w_slice_sum[k]) << (k*CHUNK));
    end

    // Skew registers travel alongside their slice; no reset needed on data.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]    <= w_a_in[k];
                r_b[k]    <= w_b_in[k];
                r_psum[k] <= w_psum_in[k];
                r_mode[k] <= w_mode_in[k];
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]    <= r_a[k];
                r_b[k]    <= r_b[k];
                r_psum[k] <= r_psum[k];
                r_mode[k] <= r_mode[k];
            end
        end
    end

    // Final stage: raw carry/borrow, signed overflow and saturation.
    always_comb begin
        w_result = w_psum_out[STAGES-1];
        w_flag   = 1'b0;
        w_ovf    = 1'b0;
        if (mode_is_sub(r_mode[STAGES-1])) begin
            w_flag = ~w_slice_cout[STAGES-1];
        end else begin
            w_flag = w_slice_cout[STAGES-1];
        end
        w_ovf = signed_ovf(r_a[STAGES-1][WIDTH-1], r_b[STAGES-1][WIDTH-1],
                           w_psum_out[STAGES-1][WIDTH-1]);
        if (mode_is_sat(r_mode[STAGES-1]) && w_flag) begin
            w_result = mode_is_sub(r_mode[STAGES-1]) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            w_result = w_psum_out[STAGES-1];
        end
    end

    // Valid chain and output registers; reset flushes every in-flight item.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
            end
            r_out_valid <= r_v[STAGES-1];
            if (r_v[STAGES-1]) begin
                r_out_sum   <= w_result;
                r_out_carry <= w_flag;
                r_out_ovf   <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=16, CHUNK=4): latency, flags,
// saturation, stalled streaming and mid-flight reset.
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry/borrow, signed overflow, result}
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] m);
        int          sa;
        int          sb;
        int          sr;
        logic [16:0] full;
        logic        c;
        logic [15:0] s;
        sa = $signed(a);
        sb = $signed(b);
        if (m[0]) begin
            c  = (a < b);
            s  = a - b;
            sr = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            c    = full[16];
            s    = full[15:0];
            sr   = sa + sb;
        end
        if (m[1] && c) s = m[0] ? 16'h0000 : 16'hFFFF;
        return {c, ((sr > 32767) || (sr < -32768)), s};
    endfunction

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                           input logic [15:0] exp_sum, input logic exp_c, input logic exp_o,
                           input string tag);
        int lat;
        in_a      = a;
        in_b      = b;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"},   {16'h0, out_sum},   {16'h0, exp_sum});
        chk({tag, "_carry"}, {31'h0, out_carry}, {31'h0, exp_c});
        chk({tag, "_ovf"},   {31'h0, out_ovf},   {31'h0, exp_o});
        @(posedge clk); #1;
    endtask

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [1:0]  vm [8];
    logic [17:0] ve [8];
    logic [3:0]  pat;
    logic [15:0] hold_sum;
    logic        hold_c;
    logic        hold_o;
    logic        was_stall;
    int          tx;
    int          rx;
    int          cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_sum",   {16'h0, out_sum},   32'h0);
        chk("rst_out_carry", {31'h0, out_carry}, 32'h0);
        chk("rst_out_ovf",   {31'h0, out_ovf},   32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        run_one(16'h000C, 16'h0007, 2'b00, 16'h0013, 1'b0, 1'b0, "add_c_7");
        run_one(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_one(16'hFFFF, 16'h0001, 2'b10, 16'hFFFF, 1'b1, 1'b0, "adds_sat");
        run_one(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_one(16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b1, 1'b0, "sub_neg");
        run_one(16'h0003, 16'h0005, 2'b11, 16'h0000, 1'b1, 1'b0, "subs_sat");
        run_one(16'h00F0, 16'h000F, 2'b01, 16'h00E1, 1'b0, 1'b0, "sub_pos");
        run_one(16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 1'b1, "sub_ovf");

        // Back-to-back stream with out_ready pattern 1,0,0,1 repeating
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom_range(0, 65535));
            vb[i] = 16'($urandom_range(0, 65535));
            vm[i] = 2'($urandom_range(0, 3));
            ve[i] = ref_model(va[i], vb[i], vm[i]);
        end
        pat       = 4'b1001;
        tx        = 0;
        rx        = 0;
        cyc       = 0;
        was_stall = 1'b0;
        while (rx < 8 && cyc < 200) begin
            if (was_stall) begin
                chk("stall_sum_stable",   {16'h0, out_sum},   {16'h0, hold_sum});
                chk("stall_carry_stable", {31'h0, out_carry}, {31'h0, hold_c});
                chk("stall_ovf_stable",   {31'h0, out_ovf},   {31'h0, hold_o});
            end
            out_ready = pat[cyc % 4];
            in_valid  = (tx < 8);
            if (tx < 8) begin
                in_a    = va[tx];
                in_b    = vb[tx];
                in_mode = vm[tx];
            end
            #1;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d_sum", rx),   {16'h0, out_sum},   {16'h0, ve[rx][15:0]});
                chk($sformatf("stream%0d_carry", rx), {31'h0, out_carry}, {31'h0, ve[rx][17]});
                chk($sformatf("stream%0d_ovf", rx),   {31'h0, out_ovf},   {31'h0, ve[rx][16]});
                rx++;
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
                hold_sum  = out_sum;
                hold_c    = out_carry;
                hold_o    = out_ovf;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_received", 32'(rx), 32'd8);
        chk("stream_sent",     32'(tx), 32'd8);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("stream_no_dup", {31'h0, out_valid}, 32'h0);
        end

        // Accept three, then reset while they are in flight
        for (int i = 0; i < 3; i++) begin
            in_a     = 16'(16'h0100 + i);
            in_b     = 16'h0011;
            in_mode  = 2'b00;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("flush_no_stale", {31'h0, out_valid}, 32'h0);
            @(posedge clk); #1;
        end
        run_one(16'h0001, 16'h0001, 2'b00, 16'h0002, 1'b0, 1'b0, "add_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
